// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b, LSB first, one bit per clock.
// A single full-subtractor cell feeds a borrow flop; results hold until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept   = (r_state != S_RUN) && start;
  assign w_last     = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs
  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_d        = w_ai ^ w_bi ^ r_bin;
  assign w_bout     = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);
  assign w_res_next = {w_d, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Operand MSBs are kept aside because the operand registers shift them out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_bin   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_next[WIDTH-1:1];
      r_bin <= w_bout;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff   <= w_res_next;
        r_borrow <= w_bout;
        r_ovf    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;

endmodule
